// File: rtl/idiv_iterative_pkg.sv
// Shared definitions for the iterative radix-2 integer divider.
package idiv_iterative_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  // Wide enough for any WIDTH up to 64; the divider casts it down to WIDTH.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX
  } idiv_state_e;

endpackage

// File: rtl/idiv_iterative.sv
// Iterative radix-2 signed/unsigned divider: start -> PREP -> WIDTH ITER steps -> FIX,
// with results and ready updating together on the final edge.
module idiv_iterative
  import idiv_iterative_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_ope,
  input  logic             write_a,
  input  logic             start,
  input  logic             flush,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DZ_QUOTIENT = WIDTH'(DIV0_QUOTIENT);

  idiv_state_e r_state;
  idiv_state_e w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_orig;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_signed;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH:0]   w_step;
  logic             w_accept;

  // One shift-subtract step: returns {next partial remainder, quotient bit}.
  function automatic logic [WIDTH:0] idiv_step(input logic [WIDTH-1:0] rem,
                                               input logic             in_bit,
                                               input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {rem, in_bit};
    diff    = shifted - {1'b0, dvs};
    if (diff[WIDTH]) idiv_step = {shifted[WIDTH-1:0], 1'b0};
    else             idiv_step = {diff[WIDTH-1:0], 1'b1};
  endfunction

  assign w_op_a   = write_a ? a : r_a;
  assign w_accept = start && !flush;
  assign w_step   = idiv_step(r_rem, r_dvd[WIDTH-1], r_dvs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_PREP;
      ST_PREP: w_next = flush ? ST_IDLE : ST_ITER;
      ST_ITER: begin
        if (flush)                   w_next = ST_IDLE;
        else if (r_cnt == LAST_STEP) w_next = ST_FIX;
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a         <= '0;
      r_orig      <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      if (r_state == ST_IDLE && write_a) r_a <= a;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_orig   <= w_op_a;
            r_dvd    <= w_op_a;
            r_dvs    <= b;
            r_signed <= signed_ope;
          end
        end
        ST_PREP: begin
          r_qneg <= r_signed && (r_orig[WIDTH-1] ^ r_dvs[WIDTH-1]);
          r_rneg <= r_signed && r_orig[WIDTH-1];
          r_dz   <= (r_dvs == '0);
          r_rem  <= '0;
          r_cnt  <= '0;
          if (r_signed && r_orig[WIDTH-1]) r_dvd <= -r_orig;
          if (r_signed && r_dvs[WIDTH-1])  r_dvs <= -r_dvs;
        end
        ST_ITER: begin
          // Quotient bits shift into the low end of the dividend register as it empties.
          r_rem <= w_step[WIDTH:1];
          r_dvd <= {r_dvd[WIDTH-2:0], w_step[0]};
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          if (!flush) begin
            if (r_dz) begin
              r_quotient  <= DZ_QUOTIENT;
              r_remainder <= r_orig;
            end else begin
              r_quotient  <= r_qneg ? -r_dvd : r_dvd;
              r_remainder <= r_rneg ? -r_rem : r_rem;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign ready     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_idiv_iterative.sv
// Self-checking bench for idiv_iterative against an arithmetic reference model.
module tb_idiv_iterative;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        signed_ope = 1'b0;
  logic        write_a = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] stored_a = '0;

  always #5 clk = ~clk;

  idiv_iterative #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .signed_ope(signed_ope),
    .write_a(write_a), .start(start), .flush(flush),
    .quotient(quotient), .remainder(remainder), .ready(ready)
  );

  // Reference: 64-bit arithmetic sidesteps the signed overflow corner entirely.
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [31:0] q, output logic [31:0] r);
    longint sx, sy;
    if (y == 0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q = 32'(sx / sy);
      r = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
  endtask

  // wmode: 0 = write_a then start, 1 = write_a with start, 2 = start only.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input int wmode, output logic fell, output int lat);
    @(negedge clk);
    if (wmode == 0) begin
      a = ta; write_a = 1'b1;
      @(negedge clk);
      write_a = 1'b0;
    end
    b = tb_v; signed_ope = ts; start = 1'b1;
    if (wmode == 1) begin a = ta; write_a = 1'b1; end
    @(posedge clk); #1;
    start = 1'b0; write_a = 1'b0;
    if (wmode != 2) stored_a = ta;
    fell = !ready;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); lat++; #1;
      if (ready) break;
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input int wmode);
    logic fell; int lat; logic [31:0] eq, er;
    run_op(ta, tb_v, ts, wmode, fell, lat);
    ref_div(stored_a, tb_v, ts, eq, er);
    n_checks += 4;
    if (fell !== 1'b1) begin n_fail++; $display("FAIL %s ready_low got=%b want=0", name, ready); end
    if (lat !== 34) begin n_fail++; $display("FAIL %s latency got=%0d want=34", name, lat); end
    if (quotient !== eq) begin n_fail++; $display("FAIL %s quotient got=%h want=%h (a=%h b=%h s=%b)", name, quotient, eq, stored_a, tb_v, ts); end
    if (remainder !== er) begin n_fail++; $display("FAIL %s remainder got=%h want=%h (a=%h b=%h s=%b)", name, remainder, er, stored_a, tb_v, ts); end
  endtask

  task automatic test_reset;
    #2;
    n_checks += 3;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", ready); end
    if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_quotient got=%h want=0", quotient); end
    if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_remainder got=%h want=0", remainder); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_unsigned;
    check_op("unsigned_100_7", 32'd100, 32'd7, 1'b0, 0);
    n_checks += 2;
    if (quotient !== 32'd14) begin n_fail++; $display("FAIL const_q_100_7 got=%0d want=14", quotient); end
    if (remainder !== 32'd2) begin n_fail++; $display("FAIL const_r_100_7 got=%0d want=2", remainder); end
  endtask

  task automatic test_signed;
    check_op("signed_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    n_checks += 2;
    if (quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL const_q_m7_2 got=%h want=fffffffd", quotient); end
    if (remainder !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL const_r_m7_2 got=%h want=ffffffff", remainder); end
    check_op("signed_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    n_checks += 2;
    if (quotient !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL const_q_7_m2 got=%h want=fffffffd", quotient); end
    if (remainder !== 32'd1) begin n_fail++; $display("FAIL const_r_7_m2 got=%h want=1", remainder); end
  endtask

  task automatic test_overflow;
    check_op("ovf_signed", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    n_checks += 2;
    if (quotient !== 32'h8000_0000) begin n_fail++; $display("FAIL const_q_ovf got=%h want=80000000", quotient); end
    if (remainder !== 32'h0) begin n_fail++; $display("FAIL const_r_ovf got=%h want=0", remainder); end
    check_op("ovf_unsigned", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    n_checks += 2;
    if (quotient !== 32'h0) begin n_fail++; $display("FAIL const_q_ovfu got=%h want=0", quotient); end
    if (remainder !== 32'h8000_0000) begin n_fail++; $display("FAIL const_r_ovfu got=%h want=80000000", remainder); end
  endtask

  task automatic test_div_zero;
    check_op("dz_unsigned", 32'd1234, 32'd0, 1'b0, 0);
    check_op("dz_signed", 32'd1234, 32'd0, 1'b1, 0);
    check_op("dz_signed_neg", 32'hFFFF_FF00, 32'd0, 1'b1, 0);
    n_checks += 1;
    if (remainder !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL const_r_dzneg got=%h want=ffffff00", remainder); end
  endtask

  task automatic test_same_cycle;
    check_op("same_cycle_write", 32'd77, 32'd10, 1'b0, 1);
    check_op("start_only_stored", 32'd0, 32'd11, 1'b0, 2);
    n_checks += 1;
    if (quotient !== 32'd7) begin n_fail++; $display("FAIL const_q_stored got=%0d want=7", quotient); end
  endtask

  task automatic test_busy;
    int cyc; logic [31:0] pq, pr;
    @(negedge clk); a = 32'd100; write_a = 1'b1;
    @(negedge clk); write_a = 1'b0; b = 32'd7; signed_ope = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    stored_a = 32'd100;
    cyc = 0;
    while (cyc < 100) begin
      if (cyc == 9) begin
        @(negedge clk); start = 1'b1; b = 32'd1; write_a = 1'b1; a = 32'd5;
      end
      @(posedge clk); cyc++; #1;
      start = 1'b0; write_a = 1'b0;
      if (ready) break;
    end
    n_checks += 3;
    if (cyc !== 34) begin n_fail++; $display("FAIL busy_latency got=%0d want=34", cyc); end
    if (quotient !== 32'd14) begin n_fail++; $display("FAIL busy_quotient got=%0d want=14", quotient); end
    if (remainder !== 32'd2) begin n_fail++; $display("FAIL busy_remainder got=%0d want=2", remainder); end
    repeat (3) @(posedge clk);
    #1;
    n_checks += 1;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL busy_no_restart got=%b want=1", ready); end
    // write_a=5 was ignored, so the stored dividend is still 100.
    check_op("busy_write_ignored", 32'd0, 32'd10, 1'b0, 2);

    pq = quotient; pr = remainder;
    @(negedge clk); a = 32'd200; write_a = 1'b1;
    @(negedge clk); write_a = 1'b0; b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    stored_a = 32'd200;
    repeat (9) @(posedge clk);
    #1;
    n_checks += 1;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL flush_busy_before got=%b want=0", ready); end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_checks += 3;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got=%b want=1", ready); end
    if (quotient !== pq) begin n_fail++; $display("FAIL flush_quotient got=%h want=%h", quotient, pq); end
    if (remainder !== pr) begin n_fail++; $display("FAIL flush_remainder got=%h want=%h", remainder, pr); end
    repeat (40) @(posedge clk);
    #1;
    n_checks += 2;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL flush_stays_idle got=%b want=1", ready); end
    if (quotient !== pq) begin n_fail++; $display("FAIL flush_hold_q got=%h want=%h", quotient, pq); end
    check_op("after_flush_9_3", 32'd9, 32'd3, 1'b0, 0);
  endtask

  task automatic test_flush_start_idle;
    logic seen_low;
    @(negedge clk); b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    seen_low = !ready;
    repeat (5) begin @(posedge clk); #1; if (!ready) seen_low = 1'b1; end
    n_checks += 1;
    if (seen_low !== 1'b0) begin n_fail++; $display("FAIL flush_start_idle ready_low got=%b want=0", seen_low); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); a = 32'd999; write_a = 1'b1;
    @(negedge clk); write_a = 1'b0; b = 32'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    #3; reset = 1'b1; #1;
    n_checks += 3;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b want=1", ready); end
    if (quotient !== 32'h0) begin n_fail++; $display("FAIL rst_mid_quotient got=%h want=0", quotient); end
    if (remainder !== 32'h0) begin n_fail++; $display("FAIL rst_mid_remainder got=%h want=0", remainder); end
    @(negedge clk); reset = 1'b0;
    stored_a = 32'd0;
    check_op("rst_zero_dividend", 32'd0, 32'd3, 1'b0, 2);
    check_op("after_rst_50_5", 32'd50, 32'd5, 1'b0, 0);
  endtask

  task automatic test_random;
    logic [31:0] ra, rb; logic rs; int wm; int sel;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 7));
      ra = $urandom;
      if (sel == 1) ra = 32'h8000_0000;
      case (sel)
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      wm = int'($urandom_range(0, 2));
      check_op("random", ra, rb, rs, wm);
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_overflow;
    test_div_zero;
    test_same_cycle;
    test_busy;
    test_flush_start_idle;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
